// File: rtl/freq_m_ctrl_if.sv
// Meter-core measurement inputs and published-result handshake.
// Handshake: res_valid/res_ready follow strict valid/ready rules -- a result
// transfers on any clock edge where both are high; while res_valid is high and
// res_ready is low the res_* payload is held stable and res_valid stays high.
interface freq_m_ctrl_if;
   logic        meas_done;
   logic [31:0] meas_freq;
   logic        meas_ovf;
   logic [31:0] res_freq;
   logic [2:0]  res_del;
   logic        res_ovf;
   logic        res_valid;
   logic        res_ready;

   // Controller side: consumes measurements, produces results.
   modport master (
      input  meas_done, meas_freq, meas_ovf, res_ready,
      output res_freq, res_del, res_ovf, res_valid
   );

   // Environment side: meter core plus result consumer.
   modport slave (
      output meas_done, meas_freq, meas_ovf, res_ready,
      input  res_freq, res_del, res_ovf, res_valid
   );
endinterface

// File: rtl/freq_m_ctrl.sv
// Measurement scheduler and auto-ranging controller for the frequency meter.
// Picks the gate divider and reference select, discards gates disturbed by
// configuration changes, steps the range and publishes qualified results.
module freq_m_ctrl #(
   parameter int unsigned MAX_DEL  = 7,
   parameter int unsigned INIT_DEL = 0,
   parameter int unsigned SETTLE_N = 1,
   parameter logic [31:0] HI_CNT   = 32'h8000_0000,
   parameter logic [31:0] LO_CNT   = 32'd1000
) (
   input  logic        clk_base,
   input  logic        reset,
   input  logic        enable,
   input  logic        auto_en,
   input  logic [2:0]  man_del,
   input  logic        man_base,
   output logic [2:0]  time_del,
   output logic [2:0]  freq_base,
   output logic        busy,
   output logic [15:0] drop_cnt,
   output logic [1:0]  state_dbg,
   freq_m_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_EVAL   = 2'd3
   } state_t;

   state_t      state, state_n;
   logic        base_sel;
   logic        auto_q;       // auto_en value the current config was applied with
   logic        enable_q;
   logic [1:0]  settle_cnt;
   logic [31:0] lat_freq;
   logic        lat_ovf;

   logic [2:0]  man_clamped;
   logic [2:0]  cfg_del;
   logic        cfg_chg;
   logic [31:0] raw;
   logic        go_up;
   logic        go_dn;

   logic        load_cfg, publish, del_up, del_dn, latch, settle_clr, settle_inc;

   assign man_clamped = (man_del > 3'(MAX_DEL)) ? 3'(MAX_DEL) : man_del;
   // Auto mode keeps its current range across a reference-only change; a fresh
   // start or a switch into auto restarts from INIT_DEL.
   assign cfg_del     = !auto_en ? man_clamped :
                        ((state != ST_IDLE) && auto_q) ? time_del : 3'(INIT_DEL);
   assign cfg_chg     = (man_base != base_sel) || (auto_en != auto_q) ||
                        (!auto_en && (man_clamped != time_del));

   assign raw   = lat_freq >> time_del;
   assign go_up = (lat_ovf || (raw > HI_CNT)) && auto_q && (time_del < 3'(MAX_DEL));
   assign go_dn = !go_up && (raw < LO_CNT) && auto_q && (time_del != 3'd0);

   assign freq_base = {2'b00, base_sel};
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // State register.
   always_ff @(posedge clk_base) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   // Next-state and per-cycle control strobes; enable low and config changes
   // take priority over any pulse or evaluation in the same cycle.
   always_comb begin
      state_n    = state;
      load_cfg   = 1'b0;
      publish    = 1'b0;
      del_up     = 1'b0;
      del_dn     = 1'b0;
      latch      = 1'b0;
      settle_clr = 1'b0;
      settle_inc = 1'b0;
      if (!enable) begin
         state_n = ST_IDLE;
      end else if (state == ST_IDLE) begin
         if (!enable_q) begin
            state_n    = ST_SETTLE;
            load_cfg   = 1'b1;
            settle_clr = 1'b1;
         end
      end else if (cfg_chg) begin
         state_n    = ST_SETTLE;
         load_cfg   = 1'b1;
         settle_clr = 1'b1;
      end else begin
         case (state)
            ST_SETTLE: begin
               if (bus.meas_done) begin
                  if (settle_cnt == 2'(SETTLE_N - 1)) begin
                     state_n    = ST_WAIT;
                     settle_clr = 1'b1;
                  end else begin
                     settle_inc = 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (bus.meas_done) begin
                  latch   = 1'b1;
                  state_n = ST_EVAL;
               end
            end
            ST_EVAL: begin
               settle_clr = 1'b1;
               if (go_up) begin
                  del_up  = 1'b1;
                  state_n = ST_SETTLE;
               end else begin
                  publish = 1'b1;
                  if (go_dn) begin
                     del_dn  = 1'b1;
                     state_n = ST_SETTLE;
                  end else begin
                     state_n = ST_WAIT;
                  end
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   // Configuration, settle counter and measurement latch.
   always_ff @(posedge clk_base) begin
      if (reset) begin
         time_del   <= 3'(INIT_DEL);
         base_sel   <= 1'b0;
         auto_q     <= 1'b0;
         enable_q   <= 1'b0;
         settle_cnt <= 2'd0;
         lat_freq   <= 32'd0;
         lat_ovf    <= 1'b0;
      end else begin
         enable_q <= enable;
         if (load_cfg) begin
            time_del <= cfg_del;
            base_sel <= man_base;
            auto_q   <= auto_en;
         end else if (del_up) begin
            time_del <= time_del + 3'd1;
         end else if (del_dn) begin
            time_del <= time_del - 3'd1;
         end
         if (settle_clr)      settle_cnt <= 2'd0;
         else if (settle_inc) settle_cnt <= settle_cnt + 2'd1;
         if (latch) begin
            lat_freq <= bus.meas_freq;
            lat_ovf  <= bus.meas_ovf;
         end
      end
   end

   // Result register with valid/ready handshake and backpressure drop counter.
   always_ff @(posedge clk_base) begin
      if (reset) begin
         bus.res_freq  <= 32'd0;
         bus.res_del   <= 3'd0;
         bus.res_ovf   <= 1'b0;
         bus.res_valid <= 1'b0;
         drop_cnt      <= 16'd0;
      end else if (publish && (!bus.res_valid || bus.res_ready)) begin
         bus.res_freq  <= lat_freq;
         bus.res_del   <= time_del;
         bus.res_ovf   <= lat_ovf;
         bus.res_valid <= 1'b1;
      end else begin
         if (publish && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         if (bus.res_valid && bus.res_ready)   bus.res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_freq_m_ctrl.sv
// Self-checking bench for freq_m_ctrl: directed scenarios with a result
// scoreboard popped whenever a result transfers.
module tb_freq_m_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_WAIT = 2'd2;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        auto_en;
   logic [2:0]  man_del;
   logic        man_base;
   logic [2:0]  time_del;
   logic [2:0]  freq_base;
   logic        busy;
   logic [15:0] drop_cnt;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard entries: {res_ovf, res_del, res_freq}.
   logic [35:0] exp_q[$];

   freq_m_ctrl_if bus ();

   freq_m_ctrl dut (
      .clk_base  (clk),
      .reset     (reset),
      .enable    (enable),
      .auto_en   (auto_en),
      .man_del   (man_del),
      .man_base  (man_base),
      .time_del  (time_del),
      .freq_base (freq_base),
      .busy      (busy),
      .drop_cnt  (drop_cnt),
      .state_dbg (state_dbg),
      .bus       (bus)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [31:0] freq, input logic ovf);
      bus.meas_done = 1'b1;
      bus.meas_freq = freq;
      bus.meas_ovf  = ovf;
      tick();
      bus.meas_done = 1'b0;
      bus.meas_freq = $urandom;
      bus.meas_ovf  = 1'b0;
   endtask

   task automatic expect_result(input logic [31:0] freq, input logic [2:0] del, input logic ovf);
      exp_q.push_back({ovf, del, freq});
   endtask

   // Scoreboard: every transfer pops one expected result.
   always @(negedge clk) begin
      if (!reset && bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", {28'd0, bus.res_ovf, bus.res_del, bus.res_freq}, 64'd0);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            check("sb_result", {28'd0, bus.res_ovf, bus.res_del, bus.res_freq}, {28'd0, e});
         end
      end
   end

   initial begin
      reset         = 1'b1;
      enable        = 1'b1;
      auto_en       = 1'b0;
      man_del       = 3'd2;
      man_base      = 1'b0;
      bus.meas_done = 1'b0;
      bus.meas_freq = 32'd0;
      bus.meas_ovf  = 1'b0;
      bus.res_ready = 1'b1;
      repeat (3) tick();

      // Reset state.
      check("rst_time_del", time_del, 0);
      check("rst_freq_base", freq_base, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_busy", busy, 0);

      // 1: manual, man_del=2; first pulse settles, second publishes.
      reset = 1'b0;
      tick();
      check("t1_state", state_dbg, S_SETTLE);
      check("t1_time_del", time_del, 2);
      check("t1_busy", busy, 1);
      pulse(32'd1234, 1'b0);
      check("t1_settled", state_dbg, S_WAIT);
      check("t1_no_result", bus.res_valid, 0);
      expect_result(32'd5_000_000, 3'd2, 1'b0);
      pulse(32'd5_000_000, 1'b0);
      check("t1_valid_early", bus.res_valid, 0);
      tick();
      check("t1_valid", bus.res_valid, 1);
      check("t1_freq", bus.res_freq, 32'd5_000_000);
      check("t1_del", bus.res_del, 2);

      // 2: auto from time_del=0; overflow steps up, then a mid-range count publishes.
      auto_en = 1'b1;
      tick();
      check("t2_state", state_dbg, S_SETTLE);
      check("t2_time_del0", time_del, 0);
      pulse(32'd0, 1'b0);
      pulse(32'd0, 1'b1);
      tick();
      check("t2_time_del1", time_del, 1);
      check("t2_no_publish", bus.res_valid, 0);
      pulse(32'd0, 1'b0);
      expect_result(32'd400_000_000, 3'd1, 1'b0);
      pulse(32'd400_000_000, 1'b0);
      tick();
      check("t2_valid", bus.res_valid, 1);
      check("t2_del", bus.res_del, 1);

      // 3: climb to time_del=3, then a low count publishes and steps down.
      pulse(32'd0, 1'b1);
      tick();
      pulse(32'd0, 1'b0);
      pulse(32'd0, 1'b1);
      tick();
      check("t3_time_del3", time_del, 3);
      pulse(32'd0, 1'b0);
      expect_result(32'd4000, 3'd3, 1'b0);
      pulse(32'd4000, 1'b0);
      tick();
      check("t3_valid", bus.res_valid, 1);
      check("t3_del", bus.res_del, 3);
      check("t3_time_del2", time_del, 2);
      check("t3_state", state_dbg, S_SETTLE);
      pulse(32'd99, 1'b0);
      tick();
      check("t3_discarded", bus.res_valid, 0);
      check("t3_wait", state_dbg, S_WAIT);

      // 4: backpressure drops two publishes, then one transfer reopens the slot.
      bus.res_ready = 1'b0;
      expect_result(32'd40_000_000, 3'd2, 1'b0);
      pulse(32'd40_000_000, 1'b0);
      tick();
      pulse(32'd8_000_000, 1'b0);
      tick();
      pulse(32'd12_000_000, 1'b0);
      tick();
      check("t4_held_freq", bus.res_freq, 32'd40_000_000);
      check("t4_held_valid", bus.res_valid, 1);
      check("t4_drop_cnt", drop_cnt, 2);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check("t4_valid_drop", bus.res_valid, 0);
      bus.res_ready = 1'b1;
      expect_result(32'd20_000_000, 3'd2, 1'b0);
      pulse(32'd20_000_000, 1'b0);
      tick();
      check("t4_accept", bus.res_freq, 32'd20_000_000);
      check("t4_drop_same", drop_cnt, 2);
      repeat (2) tick();

      // 5: reference change coinciding with a pulse discards the pulse.
      man_base = 1'b1;
      pulse(32'd30_000_000, 1'b0);
      check("t5_freq_base", freq_base, 3'd1);
      check("t5_state", state_dbg, S_SETTLE);
      tick();
      check("t5_no_publish", bus.res_valid, 0);

      // 6: enable low in SETTLE, then reset; IDLE ignores pulses.
      enable = 1'b0;
      tick();
      check("t6_idle", state_dbg, S_IDLE);
      check("t6_busy", busy, 0);
      check("t6_cfg_hold", freq_base, 3'd1);
      reset = 1'b1;
      tick();
      check("t6_rst_time_del", time_del, 0);
      check("t6_rst_freq_base", freq_base, 0);
      check("t6_rst_res_freq", bus.res_freq, 0);
      check("t6_rst_res_del", bus.res_del, 0);
      check("t6_rst_res_ovf", bus.res_ovf, 0);
      check("t6_rst_drop_cnt", drop_cnt, 0);
      reset = 1'b0;
      tick();
      pulse(32'd777_777, 1'b0);
      repeat (3) tick();
      check("t6_idle_no_result", bus.res_valid, 0);
      check("t6_idle_busy", busy, 0);

      // Manual overflow publishes a saturated result.
      auto_en  = 1'b0;
      man_del  = 3'd1;
      man_base = 1'b0;
      enable   = 1'b1;
      tick();
      check("t7_time_del", time_del, 1);
      pulse(32'd0, 1'b0);
      expect_result(32'd777, 3'd1, 1'b1);
      pulse(32'd777, 1'b1);
      tick();
      check("t7_ovf", bus.res_ovf, 1);
      check("t7_time_del_hold", time_del, 1);
      repeat (3) tick();
      check("sb_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/freq_m_ctrl.md
Name: freq_m_ctrl

Overview:
Measurement scheduler and auto-ranging controller for the frequency meter core.
- Selects the gate divider (time_del) and reference select (freq_base) for each measurement.
- Discards gates corrupted by configuration changes.
- Steps the range up or down from the raw count and overflow flag.
- Publishes qualified results to the Nios-side register file over a valid/ready handshake.
- Sits in the clk_base domain between the meter core and the CPU interface.

Parameters:
MAX_DEL, 7, largest permitted time_del (gate = base period >> time_del)
INIT_DEL, 0, time_del loaded at reset and on enable rising
SETTLE_N, 1, meas_done pulses discarded after any config change (1..3)
HI_CNT, 32'h8000_0000, raw count above which the range steps to a shorter gate
LO_CNT, 32'd1000, raw count below which the range steps to a longer gate

Ports:
clk_base  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous reset, active-high
enable  in  1  run control; low parks the block in IDLE
auto_en  in  1  1 = auto-range, 0 = manual (man_del)
man_del  in  3  manual time_del; clamped to MAX_DEL
man_base  in  1  reference select; drives freq_base[0] in both modes
meas_done  in  1  one-cycle pulse, end of gate, already synchronised to clk_base
meas_freq  in  32  scaled frequency from core, valid with meas_done
meas_ovf  in  1  count overflow during the gate, valid with meas_done
time_del  out  3  gate divider to core
freq_base  out  3  {2'b00, base_sel} to core
res_freq  out  32  published frequency
res_del  out  3  time_del used for res_freq
res_ovf  out  1  published result saturated (overflow at MAX_DEL)
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
drop_cnt  out  16  saturating count of results lost to backpressure

Behaviour:
- Reset values: time_del=INIT_DEL, freq_base=0, res_*=0, res_valid=0, drop_cnt=0, state=IDLE, settle counter=0.
- States:
  - IDLE: enable rising -> SETTLE; loads time_del (INIT_DEL if auto_en, else clamp(man_del)) and base_sel=man_base.
  - SETTLE: counts meas_done pulses and ignores their data; after SETTLE_N pulses -> WAIT.
  - WAIT: meas_done -> EVAL, latching meas_freq and meas_ovf.
  - EVAL: lasts one cycle, then returns to WAIT or SETTLE.
- Config change: man_base or man_del (in manual mode) differing from the applied value, or auto_en toggling, in SETTLE/WAIT/EVAL -> reload config next cycle, settle counter=0, -> SETTLE. A pulse arriving in that same cycle is discarded.
- EVAL decision, with raw = latched_freq >> time_del:
  - Up-range: (ovf or raw > HI_CNT), auto_en=1, time_del < MAX_DEL -> time_del+1, no publish, -> SETTLE.
  - Down-range: raw < LO_CNT, auto_en=1, time_del > 0 -> publish, then time_del-1, -> SETTLE.
  - Otherwise: publish, -> WAIT. Overflow at MAX_DEL or in manual mode publishes with res_ovf=1.
- Timing: meas_done at cycle t -> EVAL at t+1. At t+2, res_valid=1 if publishing and any time_del change is visible. res_del carries the pre-change time_del.
- Publish handshake:
  - res_valid=0 or (res_valid and res_ready) -> load res_freq/res_del/res_ovf, res_valid=1.
  - Otherwise keep the old result and increment drop_cnt (saturating at 16'hFFFF).
  - Transfer occurs when res_valid and res_ready are both high on the same edge; res_valid clears next cycle unless a publish reloads it on that edge.
- res_* outputs are stable while res_valid=1 and res_ready=0.
- enable low in any state -> IDLE next cycle. Config outputs hold, a pending result is retained, and an in-progress EVAL is abandoned.
- meas_done in IDLE is ignored.
- reset mid-operation returns all registers to their reset values on the same edge.
- Clamp: manual man_del > MAX_DEL -> time_del=MAX_DEL. Auto never exceeds MAX_DEL and never goes below 0.

Test Plan:
1. Reset, enable=1, auto_en=0, man_del=2, SETTLE_N=1. First pulse ignored; second pulse meas_freq=5_000_000 -> res_freq=5_000_000, res_del=2, res_valid at pulse+2.
2. Auto, time_del=0, pulse with meas_ovf=1 -> time_del=1 at pulse+2, no res_valid; after one settle pulse plus a pulse of 400_000_000 (raw 200M) -> published with res_del=1.
3. Auto, time_del=3, meas_freq=4000 (raw 500 < LO_CNT) -> published with res_del=3, time_del=2, one following pulse discarded.
4. res_ready=0 with a result pending, two further publishes -> res_freq unchanged, drop_cnt=2. res_ready=1 for one cycle -> res_valid drops, next publish accepted.
5. man_base toggled in WAIT in the same cycle as meas_done -> pulse discarded, freq_base[0] updated next cycle, state SETTLE.
6. enable deasserted during SETTLE, then reset asserted -> IDLE, busy=0, all outputs at reset values; meas_done in IDLE produces no result.
